// File: rtl/regfile_pkg.sv
// Shared constants and flattened-bus index helpers for the regfile_sb register file.
package regfile_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int ZERO_REG       = 0;

  function automatic int addr_lsb(input int port, input int addr_w);
    return port * addr_w;
  endfunction

  function automatic int data_lsb(input int port, input int data_w);
    return port * data_w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-load busy bits: flush beats set, set beats a same-address clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       set_i,
  input  logic [ADDR_WIDTH-1:0]      set_addr_i,
  input  logic                       clr_i,
  input  logic [ADDR_WIDTH-1:0]      clr_addr_i,
  input  logic                       flush_i,
  output logic [2**ADDR_WIDTH-1:0]   busy_o,
  output logic                       any_busy_o
);

  logic [2**ADDR_WIDTH-1:0] busy_q;
  logic [2**ADDR_WIDTH-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      // Clear first so a back-to-back load to the same register stays busy.
      if (clr_i && (clr_addr_i != ADDR_WIDTH'(ZERO_REG))) busy_d[clr_addr_i] = 1'b0;
      if (set_i && (set_addr_i != ADDR_WIDTH'(ZERO_REG))) busy_d[set_addr_i] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o     = busy_q;
  assign any_busy_o = |busy_q;

endmodule

// File: rtl/regfile_sb.sv
// GPR array with two prioritised write ports, optional write-to-read bypass and a
// pending-load scoreboard; x0 reads as zero and is never written.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NREAD      = 2,
  parameter int BYPASS     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREAD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NREAD*DATA_WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]            rd_busy,
  input  logic                        wen0,
  input  logic [ADDR_WIDTH-1:0]       waddr0,
  input  logic [DATA_WIDTH-1:0]       wdata0,
  input  logic                        wen1,
  input  logic [ADDR_WIDTH-1:0]       waddr1,
  input  logic [DATA_WIDTH-1:0]       wdata1,
  input  logic                        sb_set,
  input  logic [ADDR_WIDTH-1:0]       sb_addr,
  input  logic                        flush,
  output logic                        any_busy,
  input  logic [ADDR_WIDTH-1:0]       dbg_addr,
  output logic [DATA_WIDTH-1:0]       dbg_data
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_q [DEPTH];
  logic [DEPTH-1:0]      busy;

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) rf_q[j] <= '0;
    end else begin
      if (wen0 && (waddr0 != ADDR_WIDTH'(ZERO_REG))) rf_q[waddr0] <= wdata0;
      if (wen1 && (waddr1 != ADDR_WIDTH'(ZERO_REG))) rf_q[waddr1] <= wdata1;
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (sb_set),
    .set_addr_i (sb_addr),
    .clr_i      (wen1),
    .clr_addr_i (waddr1),
    .flush_i    (flush),
    .busy_o     (busy),
    .any_busy_o (any_busy)
  );

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rdat;
    logic                  rbusy;

    assign ra = rd_addr[addr_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];

    // A port-1 hit also hides the busy bit because its data is already forwarded.
    always_comb begin
      rdat  = rf_q[ra];
      rbusy = busy[ra];
      if (BYPASS != 0) begin
        if (wen1 && (waddr1 == ra)) begin
          rdat  = wdata1;
          rbusy = 1'b0;
        end else if (wen0 && (waddr0 == ra)) begin
          rdat = wdata0;
        end
      end
      if (ra == ADDR_WIDTH'(ZERO_REG)) rdat = '0;
    end

    assign rd_data[data_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = rdat;
    assign rd_busy[i] = rbusy;
  end

  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb; a bypassing and a non-bypassing instance share all inputs.
module tb_regfile_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

  logic             clk;
  logic             rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic             wen0, wen1, sb_set, flush;
  logic [AW-1:0]    waddr0, waddr1, sb_addr, dbg_addr;
  logic [DW-1:0]    wdata0, wdata1;

  logic [NR*DW-1:0] rd_data_bp, rd_data_nb;
  logic [NR-1:0]    rd_busy_bp, rd_busy_nb;
  logic             any_busy_bp, any_busy_nb;
  logic [DW-1:0]    dbg_data_bp, dbg_data_nb;

  regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_bp), .rd_busy(rd_busy_bp),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush), .any_busy(any_busy_bp),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_bp)
  );

  regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .sb_set(sb_set), .sb_addr(sb_addr), .flush(flush), .any_busy(any_busy_nb),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $error("FAIL scoreboard_underflow: observed %h with no expected value", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        tests_failed++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance one rising edge and leave 1 time unit of hold before new stimulus.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle_writes();
    wen0 = 1'b0; waddr0 = '0; wdata0 = '0;
    wen1 = 1'b0; waddr1 = '0; wdata1 = '0;
    sb_set = 1'b0; sb_addr = '0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr = '0;
    dbg_addr = '0;
    idle_writes();
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    settle();
    expect_val("post_reset_any_busy", 32'd0); chk(32'(any_busy_bp));
    expect_val("post_reset_rd_busy", 32'd0);  chk(32'(rd_busy_bp));

    // Preload r5, then reset with a write and sb_set pending on r6
    wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
    step();
    idle_writes();
    set_rd(5'd5, 5'd6);
    dbg_addr = 5'd5;
    settle();
    expect_val("preload_r5", 32'hDEAD_BEEF); chk(rd_data_bp[31:0]);
    rst_n = 1'b0;
    wen1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h0000_0123;
    sb_set = 1'b1; sb_addr = 5'd6;
    step();
    rst_n = 1'b1;
    idle_writes();
    settle();
    expect_val("reset_r5_rd", 32'd0);      chk(rd_data_bp[31:0]);
    expect_val("reset_r5_dbg", 32'd0);     chk(dbg_data_bp);
    expect_val("reset_r6_dropped", 32'd0); chk(rd_data_bp[63:32]);
    expect_val("reset_r6_busy", 32'd0);    chk(32'(rd_busy_bp[1]));
    expect_val("reset_any_busy", 32'd0);   chk(32'(any_busy_bp));

    // x0 stays zero, same cycle and next cycle
    wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h0000_1234;
    set_rd(5'd0, 5'd0);
    dbg_addr = 5'd0;
    settle();
    expect_val("x0_bypass_read", 32'd0); chk(rd_data_bp[31:0]);
    step();
    idle_writes();
    settle();
    expect_val("x0_read", 32'd0); chk(rd_data_bp[31:0]);
    expect_val("x0_dbg", 32'd0);  chk(dbg_data_bp);

    // Port 1 wins a same-address collision
    wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h11;
    wen1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h22;
    set_rd(5'd3, 5'd3);
    settle();
    expect_val("prio_bypass", 32'h22); chk(rd_data_bp[31:0]);
    expect_val("prio_nobypass_old", 32'h0); chk(rd_data_nb[31:0]);
    expect_val("prio_nb_next", 32'h22);
    expect_val("prio_dbg_next", 32'h22);
    step();
    idle_writes();
    dbg_addr = 5'd3;
    settle();
    chk(rd_data_nb[31:0]);
    chk(dbg_data_bp);

    // Bypass vs array-only read of r7
    set_rd(5'd7, 5'd0);
    wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h0000_A5A5;
    settle();
    expect_val("bypass_same_cycle", 32'h0000_A5A5); chk(rd_data_bp[31:0]);
    expect_val("nobypass_old", 32'h0);              chk(rd_data_nb[31:0]);
    expect_val("nobypass_next", 32'h0000_A5A5);
    step();
    idle_writes();
    settle();
    chk(rd_data_nb[31:0]);

    // Scoreboard life cycle on r9
    set_rd(5'd0, 5'd9);
    sb_set = 1'b1; sb_addr = 5'd9;
    settle();
    expect_val("sb_set_not_yet", 32'd0); chk(32'(rd_busy_bp[1]));
    step();
    idle_writes();
    settle();
    expect_val("sb_busy", 32'd1);     chk(32'(rd_busy_bp[1]));
    expect_val("sb_any_busy", 32'd1); chk(32'(any_busy_bp));
    expect_val("sb_busy_nb", 32'd1);  chk(32'(rd_busy_nb[1]));
    wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h77;
    settle();
    expect_val("clr_busy_bypass", 32'd0);  chk(32'(rd_busy_bp[1]));
    expect_val("clr_data_bypass", 32'h77); chk(rd_data_bp[63:32]);
    expect_val("clr_busy_nb_still", 32'd1); chk(32'(rd_busy_nb[1]));
    expect_val("clr_any_busy_registered", 32'd1); chk(32'(any_busy_bp));
    step();
    idle_writes();
    settle();
    expect_val("clr_busy_after", 32'd0);    chk(32'(rd_busy_bp[1]));
    expect_val("clr_busy_nb_after", 32'd0); chk(32'(rd_busy_nb[1]));
    expect_val("clr_any_after", 32'd0);     chk(32'(any_busy_bp));
    expect_val("clr_data_nb_after", 32'h77); chk(rd_data_nb[63:32]);

    // Set/clear collision on r4, then flush with a concurrent write
    set_rd(5'd4, 5'd10);
    sb_set = 1'b1; sb_addr = 5'd4;
    step();
    wen1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h5;
    step();
    idle_writes();
    settle();
    expect_val("coll_data", 32'h5);     chk(rd_data_nb[31:0]);
    expect_val("coll_busy", 32'd1);     chk(32'(rd_busy_bp[0]));
    expect_val("coll_any_busy", 32'd1); chk(32'(any_busy_bp));
    flush = 1'b1;
    wen0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h0000_0ABC;
    settle();
    expect_val("flush_not_yet", 32'd1); chk(32'(any_busy_bp));
    step();
    idle_writes();
    settle();
    expect_val("flush_any_busy", 32'd0); chk(32'(any_busy_bp));
    expect_val("flush_rd_busy", 32'd0);  chk(32'(rd_busy_bp[0]));
    expect_val("flush_keeps_write", 32'h0000_0ABC); chk(rd_data_nb[63:32]);
    expect_val("flush_keeps_r4", 32'h5); chk(rd_data_nb[31:0]);

    // Mid-operation reset with busy r2/r12 and a pending write to r2
    sb_set = 1'b1; sb_addr = 5'd2;
    step();
    sb_addr = 5'd12;
    step();
    idle_writes();
    set_rd(5'd2, 5'd12);
    settle();
    expect_val("pre_rst_busy_r2", 32'd1);  chk(32'(rd_busy_bp[0]));
    expect_val("pre_rst_busy_r12", 32'd1); chk(32'(rd_busy_bp[1]));
    rst_n = 1'b0;
    wen1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h99;
    step();
    rst_n = 1'b1;
    idle_writes();
    dbg_addr = 5'd3;
    settle();
    expect_val("midrst_any_busy", 32'd0); chk(32'(any_busy_bp));
    expect_val("midrst_busy_r2", 32'd0);  chk(32'(rd_busy_nb[0]));
    expect_val("midrst_busy_r12", 32'd0); chk(32'(rd_busy_nb[1]));
    expect_val("midrst_r2_dropped", 32'd0); chk(rd_data_nb[31:0]);
    expect_val("midrst_r3_cleared", 32'd0); chk(dbg_data_bp);

    tests_run++;
    assert (exp_q.size() === 0) else begin
      tests_failed++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
